// File: rtl/prbs_bert_engine.sv
// PRBS bit-error-rate engine: multi-polynomial pattern generator and self-synchronising checker.
// Handles DATA_W bits per clock, MSB first in time, with lock tracking, saturating counters and error injection.
module prbs_bert_engine #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ERR_W      = 16,
  parameter int unsigned LOCK_WORDS = 16,
  parameter int unsigned LOSS_WORDS = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              inject_err,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              locked,
  output logic              running,
  output logic [ERR_W-1:0]  err_count,
  output logic [CNT_W-1:0]  bit_count,
  output logic              err_sat,
  output logic              bit_sat
);

  localparam int unsigned LFSR_W  = 15;
  localparam int unsigned POP_W   = $clog2(DATA_W + 1);
  localparam int unsigned FILL_W  = 5;
  localparam int unsigned CLEAN_W = $clog2(LOCK_WORDS + 1);
  localparam int unsigned BAD_W   = $clog2(LOSS_WORDS + 1);
  localparam int unsigned ESUM_W  = ERR_W + POP_W;
  localparam int unsigned BSUM_W  = CNT_W + 6;
  localparam logic [POP_W-1:0] BAD_THR = POP_W'(DATA_W / 4);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_LOCKED} state_t;

  // Feedback bit of the selected polynomial; a shorter register only uses its low bits.
  function automatic logic fb(input logic [LFSR_W-1:0] s, input logic [1:0] m);
    case (m)
      2'b00:   fb = s[6] ^ s[5];
      2'b01:   fb = s[8] ^ s[4];
      2'b10:   fb = s[12] ^ s[11] ^ s[1] ^ s[0];
      default: fb = s[14] ^ s[13];
    endcase
  endfunction

  function automatic logic [FILL_W-1:0] fill_words(input logic [1:0] m);
    int unsigned n;
    case (m)
      2'b00:   n = 7;
      2'b01:   n = 9;
      2'b10:   n = 13;
      default: n = 15;
    endcase
    return FILL_W'((n + DATA_W - 1) / DATA_W);
  endfunction

  logic [1:0]         r_mode;
  logic               r_running;
  logic [LFSR_W-1:0]  r_gen;
  logic [LFSR_W-1:0]  r_chk;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_tx_valid;
  logic               r_locked;
  state_t             r_state, w_state_nxt;
  logic [FILL_W-1:0]  r_fill, w_fill_nxt;
  logic [CLEAN_W-1:0] r_clean_run, w_clean_nxt;
  logic [BAD_W-1:0]   r_bad_run, w_bad_nxt;
  logic [ERR_W-1:0]   r_err;
  logic [CNT_W-1:0]   r_bit;
  logic               r_err_sat, r_bit_sat;

  logic [1:0]         w_gen_mode;
  logic [LFSR_W-1:0]  w_gen_s;
  logic [DATA_W-1:0]  w_gen_word;
  logic               w_gen_fb;
  logic [LFSR_W-1:0]  w_chk_s;
  logic [DATA_W-1:0]  w_rx_sh;
  logic               w_pred, w_rb, w_in_lock;
  logic [POP_W-1:0]   w_pop;
  logic               w_step, w_clean_word, w_bad_word, w_count;
  logic [ESUM_W-1:0]  w_err_sum;
  logic [BSUM_W-1:0]  w_bit_sum;

  // Generator: DATA_W LFSR steps per clock, reseeded to all-ones on start.
  always_comb begin
    w_gen_mode = start ? mode : r_mode;
    w_gen_s    = start ? '1 : r_gen;
    w_gen_word = '0;
    w_gen_fb   = 1'b0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      w_gen_fb   = fb(w_gen_s, w_gen_mode);
      w_gen_word = DATA_W'({w_gen_word, w_gen_fb});
      w_gen_s    = {w_gen_s[LFSR_W-2:0], w_gen_fb};
    end
  end

  // Checker history takes received bits while hunting and its own predictions once locked.
  always_comb begin
    w_in_lock = (r_state == S_LOCKED);
    w_chk_s   = r_chk;
    w_rx_sh   = rx_data;
    w_pop     = '0;
    w_pred    = 1'b0;
    w_rb      = 1'b0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      w_pred  = fb(w_chk_s, r_mode);
      w_rb    = w_rx_sh[DATA_W-1];
      w_pop   = w_pop + POP_W'(w_rb ^ w_pred);
      w_chk_s = {w_chk_s[LFSR_W-2:0], w_in_lock ? w_pred : w_rb};
      w_rx_sh = DATA_W'({w_rx_sh, 1'b0});
    end
  end

  assign w_step       = rx_valid && r_running && !start && !stop;
  assign w_clean_word = (w_pop == '0);
  assign w_bad_word   = (w_pop > BAD_THR);
  assign w_count      = w_step && w_in_lock;
  assign w_err_sum    = ESUM_W'(r_err) + ESUM_W'(w_pop);
  assign w_bit_sum    = BSUM_W'(r_bit) + BSUM_W'(DATA_W);

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_clean_nxt = r_clean_run;
    w_bad_nxt   = r_bad_run;
    if (start) begin
      w_state_nxt = S_HUNT;
      w_fill_nxt  = fill_words(mode);
      w_clean_nxt = '0;
      w_bad_nxt   = '0;
    end else if (stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_step) begin
      case (r_state)
        S_HUNT: begin
          if (r_fill != '0) begin
            w_fill_nxt  = r_fill - FILL_W'(1);
            w_clean_nxt = '0;
          end else if (!w_clean_word) begin
            w_clean_nxt = '0;
          end else if (r_clean_run == CLEAN_W'(LOCK_WORDS - 1)) begin
            w_state_nxt = S_LOCKED;
            w_clean_nxt = '0;
            w_bad_nxt   = '0;
          end else begin
            w_clean_nxt = r_clean_run + CLEAN_W'(1);
          end
        end
        S_LOCKED: begin
          if (!w_bad_word) begin
            w_bad_nxt = '0;
          end else if (r_bad_run == BAD_W'(LOSS_WORDS - 1)) begin
            w_state_nxt = S_HUNT;
            w_fill_nxt  = fill_words(r_mode);
            w_clean_nxt = '0;
            w_bad_nxt   = '0;
          end else begin
            w_bad_nxt = r_bad_run + BAD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_fill      <= '0;
      r_clean_run <= '0;
      r_bad_run   <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill      <= w_fill_nxt;
      r_clean_run <= w_clean_nxt;
      r_bad_run   <= w_bad_nxt;
      r_locked    <= (w_state_nxt == S_LOCKED);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= 2'b00;
      r_running  <= 1'b0;
      r_gen      <= '1;
      r_chk      <= '1;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      if (start) begin
        r_mode     <= mode;
        r_running  <= 1'b1;
        r_gen      <= w_gen_s;
        r_tx_data  <= w_gen_word;
        r_tx_valid <= 1'b1;
      end else if (stop) begin
        r_running  <= 1'b0;
        r_tx_valid <= 1'b0;
      end else if (r_running) begin
        r_gen      <= w_gen_s;
        r_tx_data  <= w_gen_word ^ DATA_W'(inject_err);
        r_tx_valid <= 1'b1;
      end
      if (start) begin
        r_chk <= '1;
      end else if (w_step) begin
        r_chk <= w_chk_s;
      end
    end
  end

  // Counters saturate at all-ones; clear overrides a same-cycle increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err     <= '0;
      r_bit     <= '0;
      r_err_sat <= 1'b0;
      r_bit_sat <= 1'b0;
    end else if (clear) begin
      r_err     <= '0;
      r_bit     <= '0;
      r_err_sat <= 1'b0;
      r_bit_sat <= 1'b0;
    end else if (w_count) begin
      if (w_err_sum >= ESUM_W'(ERR_MAX)) begin
        r_err     <= ERR_MAX;
        r_err_sat <= 1'b1;
      end else begin
        r_err <= ERR_W'(w_err_sum);
      end
      if (w_bit_sum >= BSUM_W'(CNT_MAX)) begin
        r_bit     <= CNT_MAX;
        r_bit_sat <= 1'b1;
      end else begin
        r_bit <= CNT_W'(w_bit_sum);
      end
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign locked    = r_locked;
  assign running   = r_running;
  assign err_count = r_err;
  assign bit_count = r_bit;
  assign err_sat   = r_err_sat;
  assign bit_sat   = r_bit_sat;

endmodule

// File: tb/tb_prbs_bert_engine.sv
// Bench for prbs_bert_engine: loopback channel with corruption, a sequence-recurrence reference
// model compared every cycle, and hand-computed literal checks for pattern words and counter limits.
module tb_prbs_bert_engine;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 10;
  localparam int unsigned EW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode;
  logic          start, stop, clear, inject_err;
  logic [DW-1:0] tx_data, rx_data, rx_xor;
  logic          tx_valid, rx_valid;
  logic          locked, running, err_sat, bit_sat;
  logic [EW-1:0] err_count;
  logic [CW-1:0] bit_count;

  always #5 clk = ~clk;

  assign rx_data  = tx_data ^ rx_xor;
  assign rx_valid = tx_valid;

  prbs_bert_engine #(.DATA_W(DW), .CNT_W(CW), .ERR_W(EW), .LOCK_WORDS(16), .LOSS_WORDS(4)) dut (
    .clock(clk), .reset_n(rst_n), .mode(mode), .start(start), .stop(stop), .clear(clear),
    .inject_err(inject_err), .tx_data(tx_data), .tx_valid(tx_valid), .rx_data(rx_data),
    .rx_valid(rx_valid), .locked(locked), .running(running), .err_count(err_count),
    .bit_count(bit_count), .err_sat(err_sat), .bit_sat(bit_sat));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: h[d] is the sequence bit d positions back; polynomial exponents are the delays.
  bit          m_running, m_tx_valid;
  bit [DW-1:0] m_tx_data;
  int          m_mode, m_phase, m_fill, m_clean, m_bad, m_err, m_bits;
  bit          m_err_sat, m_bit_sat;
  bit [15:1]   g_hist, c_hist;

  function automatic bit poly_next(input bit [15:1] h, input int m);
    case (m)
      0:       return h[7] ^ h[6];
      1:       return h[9] ^ h[5];
      2:       return h[13] ^ h[12] ^ h[2] ^ h[1];
      default: return h[15] ^ h[14];
    endcase
  endfunction

  function automatic int degree(input int m);
    case (m)
      0:       return 7;
      1:       return 9;
      2:       return 13;
      default: return 15;
    endcase
  endfunction

  task automatic model_reset();
    m_running = 0; m_tx_valid = 0; m_tx_data = '0; m_mode = 0; m_phase = 0;
    m_fill = 0; m_clean = 0; m_bad = 0; m_err = 0; m_bits = 0;
    m_err_sat = 0; m_bit_sat = 0; g_hist = '1; c_hist = '1;
  endtask

  task automatic gen_word(output bit [DW-1:0] w);
    bit b;
    for (int i = DW - 1; i >= 0; i--) begin
      b = poly_next(g_hist, m_mode);
      w[i] = b;
      g_hist = {g_hist[14:1], b};
    end
  endtask

  task automatic model_step();
    bit [DW-1:0] rxw, w;
    bit p, r;
    int e;
    rxw = m_tx_data ^ rx_xor;
    if (start) begin
      m_phase = 1; m_fill = (degree(int'(mode)) + DW - 1) / DW;
      m_clean = 0; m_bad = 0; c_hist = '1;
    end else if (stop) begin
      m_phase = 0;
    end else if (m_tx_valid && m_running && m_phase != 0) begin
      e = 0;
      for (int i = DW - 1; i >= 0; i--) begin
        p = poly_next(c_hist, m_mode);
        r = rxw[i];
        if (p != r) e++;
        c_hist = {c_hist[14:1], (m_phase == 2) ? p : r};
      end
      if (m_phase == 2) begin
        m_err = m_err + e;
        if (m_err >= 15) begin m_err = 15; m_err_sat = 1; end
        m_bits = m_bits + DW;
        if (m_bits >= 1023) begin m_bits = 1023; m_bit_sat = 1; end
        if (e > DW / 4) m_bad++; else m_bad = 0;
        if (m_bad == 4) begin
          m_phase = 1; m_fill = (degree(m_mode) + DW - 1) / DW; m_clean = 0; m_bad = 0;
        end
      end else if (m_fill > 0) begin
        m_fill--;
      end else if (e == 0) begin
        m_clean++;
        if (m_clean == 16) begin m_phase = 2; m_clean = 0; m_bad = 0; end
      end else begin
        m_clean = 0;
      end
    end
    if (clear) begin
      m_err = 0; m_bits = 0; m_err_sat = 0; m_bit_sat = 0;
    end
    if (start) begin
      m_mode = int'(mode); g_hist = '1; m_running = 1; m_tx_valid = 1;
      gen_word(w); m_tx_data = w;
    end else if (stop) begin
      m_running = 0; m_tx_valid = 0;
    end else if (m_running) begin
      gen_word(w); m_tx_data = w ^ DW'(inject_err); m_tx_valid = 1;
    end
  endtask

  initial model_reset();

  // Compare on the falling edge, then advance the model with the inputs the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    check("m_tx_valid", tx_valid, m_tx_valid);
    if (m_tx_valid) check("m_tx_data", tx_data, m_tx_data);
    check("m_running", running, m_running);
    check("m_locked", locked, m_phase == 2);
    check("m_err_count", err_count, m_err);
    check("m_bit_count", bit_count, m_bits);
    check("m_err_sat", err_sat, m_err_sat);
    check("m_bit_sat", bit_sat, m_bit_sat);
    if (rst_n) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode = m; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    while (!locked && n < 100) begin
      if (rx_valid) n++;
      tick();
    end
  endtask

  logic [DW-1:0] first_word [4];
  int            n, lw;

  initial begin
    first_word[0] = 8'h02; first_word[1] = 8'h07; first_word[2] = 8'h6D; first_word[3] = 8'h00;
    mode = 2'b00; start = 0; stop = 0; clear = 0; inject_err = 0; rx_xor = '0;
    tick(); tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_running", running, 0);
    check("rst_locked", locked, 0);
    rst_n = 1'b1;
    tick();

    pulse_start(2'b00);
    check("prbs7_word0", tx_data, 8'h02);
    check("prbs7_valid0", tx_valid, 1);
    tick();
    check("prbs7_word1", tx_data, 8'h0C);
    pulse_stop();
    tick();
    check("stop_tx_valid", tx_valid, 0);

    for (int m = 0; m < 4; m++) begin
      pulse_clear();
      pulse_start(2'(m));
      check("first_word", tx_data, first_word[m]);
      wait_lock(n);
      check("lock_latency", n, (m == 0) ? 17 : 18);
      lw = 0;
      repeat (10) begin
        if (locked && rx_valid) lw++;
        tick();
      end
      check("loop_err_zero", err_count, 0);
      check("loop_bit_count", bit_count, 8 * lw);
      pulse_stop();
      tick();
    end

    pulse_clear();
    pulse_start(2'b00);
    wait_lock(n);
    repeat (3) begin
      inject_err = 1'b1; tick(); inject_err = 1'b0;
      repeat (4) tick();
    end
    check("inject_err_count", err_count, 3);
    check("inject_locked", locked, 1);

    rx_xor = 8'hFF;
    repeat (3) tick();
    check("loss_3_bad", locked, 1);
    tick();
    check("loss_4_bad", locked, 0);
    rx_xor = 8'h00;
    wait_lock(n);
    check("relock_latency", n, 17);

    pulse_clear();
    rx_xor = 8'h01;
    repeat (14) tick();
    check("err_14", err_count, 4'hE);
    check("err_sat_14", err_sat, 0);
    tick();
    check("err_15", err_count, 4'hF);
    check("err_sat_15", err_sat, 1);
    repeat (5) tick();
    check("err_20", err_count, 4'hF);
    check("err_locked", locked, 1);
    rx_xor = 8'h00;
    pulse_clear();
    check("clear_err", err_count, 0);
    check("clear_err_sat", err_sat, 0);

    repeat (127) tick();
    check("bit_127", bit_count, 10'h3F8);
    check("bit_sat_127", bit_sat, 0);
    tick();
    check("bit_128", bit_count, 10'h3FF);
    check("bit_sat_128", bit_sat, 1);

    mode = 2'b11;
    repeat (6) tick();
    check("mode_ignored_locked", locked, 1);
    check("mode_ignored_err", err_count, 0);

    rst_n = 1'b0;
    #1;
    check("async_tx_valid", tx_valid, 0);
    check("async_tx_data", tx_data, 0);
    check("async_running", running, 0);
    check("async_locked", locked, 0);
    check("async_err", err_count, 0);
    check("async_bits", bit_count, 0);
    check("async_bit_sat", bit_sat, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    pulse_start(2'b01);
    check("prbs9_after_reset", tx_data, 8'h07);
    wait_lock(n);
    check("prbs9_relock", n, 18);
    pulse_stop();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
